// File: rtl/stump_cond_unit_if.sv
// Request/response and flag bus between the decode/ALU side and the Stump condition unit.
interface stump_cond_unit_if;
    logic [3:0] flags_in;
    logic       flags_we;
    logic       flags_pending;
    logic       cond_valid;
    logic [3:0] cond;
    logic       cond_ready;
    logic       br_valid;
    logic       br_taken;
    logic       br_ready;
    logic [3:0] cc_out;

    modport master (
        output flags_in, flags_we, flags_pending, cond_valid, cond, br_ready,
        input  cond_ready, br_valid, br_taken, cc_out
    );

    modport slave (
        input  flags_in, flags_we, flags_pending, cond_valid, cond, br_ready,
        output cond_ready, br_valid, br_taken, cc_out
    );
endinterface

// File: rtl/stump_cond_unit.sv
// Stump branch-condition unit: holds the NZVC register and resolves condition requests,
// stalling while a flag-setting ALU op is still in flight.
module stump_cond_unit #(
    parameter logic [3:0] CC_RESET = 4'b0000
) (
    input logic              clk,
    input logic              rst_n,
    stump_cond_unit_if.slave bus
);
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned COND_W = 4;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t              state_q, state_d;
    logic [FLAG_W-1:0]   cc_q;
    logic [COND_W-1:0]   cond_q, cond_d;
    logic                br_valid_q, br_valid_d;
    logic                br_taken_q, br_taken_d;
    logic                cond_ready_q, cond_ready_d;
    logic [FLAG_W-1:0]   eff_flags_c;
    logic                accept_c;

    // Flags written this cycle bypass the register so a same-cycle request sees them.
    assign eff_flags_c = bus.flags_we ? bus.flags_in : cc_q;
    assign accept_c    = bus.cond_valid && (state_q == IDLE);

    function automatic logic cond_eval(input logic [COND_W-1:0] c, input logic [FLAG_W-1:0] f);
        logic n, z, v, cy;
        logic res;
        n   = f[3];
        z   = f[2];
        v   = f[1];
        cy  = f[0];
        res = 1'b0;
        case (c)
            4'h0: res = 1'b1;
            4'h1: res = 1'b0;
            4'h2: res = ~cy & ~z;
            4'h3: res = cy | z;
            4'h4: res = ~cy;
            4'h5: res = cy;
            4'h6: res = ~z;
            4'h7: res = z;
            4'h8: res = ~v;
            4'h9: res = v;
            4'hA: res = ~n;
            4'hB: res = n;
            4'hC: res = n ~^ v;
            4'hD: res = n ^ v;
            4'hE: res = ~z & (n ~^ v);
            default: res = z | (n ^ v);
        endcase
        return res;
    endfunction

    // State and registered outputs; reset also masks any same-cycle flag write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cc_q         <= CC_RESET;
            cond_q       <= '0;
            br_valid_q   <= 1'b0;
            br_taken_q   <= 1'b0;
            cond_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            if (bus.flags_we) begin
                cc_q <= bus.flags_in;
            end
            cond_q       <= cond_d;
            br_valid_q   <= br_valid_d;
            br_taken_q   <= br_taken_d;
            cond_ready_q <= cond_ready_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    state_d = (bus.flags_pending && !bus.flags_we) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (bus.flags_we || !bus.flags_pending) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.br_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; the decision is frozen once RESP is entered.
    always_comb begin
        cond_d       = cond_q;
        br_taken_d   = br_taken_q;
        br_valid_d   = (state_d == RESP);
        cond_ready_d = (state_d == IDLE);
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    cond_d = bus.cond;
                    if (state_d == RESP) begin
                        br_taken_d = cond_eval(bus.cond, eff_flags_c);
                    end
                end
            end
            WAIT: begin
                if (state_d == RESP) begin
                    br_taken_d = cond_eval(cond_q, eff_flags_c);
                end
            end
            default: ;
        endcase
    end

    assign bus.cond_ready = cond_ready_q;
    assign bus.br_valid   = br_valid_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.cc_out     = cc_q;
endmodule

// File: tb/tb_stump_cond_unit.sv
// Directed bench for stump_cond_unit with an expected-decision scoreboard.
module tb_stump_cond_unit;
    localparam logic [3:0] CC_RESET = 4'b0000;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic exp_q[$];
    logic [3:0] cc_m;

    stump_cond_unit_if bus ();

    stump_cond_unit #(.CC_RESET(CC_RESET)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: conditions come in complementary even/odd pairs.
    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic n, z, v, cy, base;
        n = f[3]; z = f[2]; v = f[1]; cy = f[0];
        case (c[3:1])
            3'd0: base = 1'b1;
            3'd1: base = !cy && !z;
            3'd2: base = !cy;
            3'd3: base = !z;
            3'd4: base = !v;
            3'd5: base = !n;
            3'd6: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a decision, score it against the queue, then hand-shake it away.
    task automatic take_resp(input string tag);
        logic exp;
        int n;
        n = 0;
        while (bus.br_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 4'(bus.br_valid), 4'd1);
        chk({tag, "_sb"}, 4'(exp_q.size() != 0), 4'd1);
        if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            chk({tag, "_taken"}, 4'(bus.br_taken), 4'(exp));
        end
        bus.br_ready = 1'b1;
        tick();
        bus.br_ready = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.flags_in      = '0;
        bus.flags_we      = 1'b0;
        bus.flags_pending = 1'b0;
        bus.cond_valid    = 1'b0;
        bus.cond          = '0;
        bus.br_ready      = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        cc_m  = CC_RESET;

        chk("rst_cc", bus.cc_out, CC_RESET);
        chk("rst_ready", 4'(bus.cond_ready), 4'd1);
        chk("rst_valid", 4'(bus.br_valid), 4'd0);
        chk("rst_taken", 4'(bus.br_taken), 4'd0);

        // EQ with no flag activity, latency 1
        bus.cond_valid = 1'b1; bus.cond = 4'h7;
        exp_q.push_back(model(4'h7, cc_m));
        tick();
        bus.cond_valid = 1'b0;
        chk("eq_lat1", 4'(bus.br_valid), 4'd1);
        chk("eq_busy", 4'(bus.cond_ready), 4'd0);
        take_resp("eq");
        chk("eq_idle_valid", 4'(bus.br_valid), 4'd0);
        chk("eq_idle_ready", 4'(bus.cond_ready), 4'd1);

        // Same-cycle flag write is bypassed into the evaluation
        bus.cond_valid = 1'b1; bus.cond = 4'h7;
        bus.flags_we = 1'b1; bus.flags_in = 4'b0100;
        exp_q.push_back(model(4'h7, 4'b0100));
        cc_m = 4'b0100;
        tick();
        bus.cond_valid = 1'b0; bus.flags_we = 1'b0;
        chk("byp_lat1", 4'(bus.br_valid), 4'd1);
        chk("byp_cc", bus.cc_out, cc_m);
        take_resp("byp");

        // GE with flags pending; flags arrive three cycles later
        bus.flags_pending = 1'b1;
        bus.cond_valid = 1'b1; bus.cond = 4'hC;
        tick();
        bus.cond_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("wait_valid", 4'(bus.br_valid), 4'd0);
            chk("wait_ready", 4'(bus.cond_ready), 4'd0);
            tick();
        end
        chk("wait_valid", 4'(bus.br_valid), 4'd0);
        chk("wait_ready", 4'(bus.cond_ready), 4'd0);
        bus.flags_we = 1'b1; bus.flags_in = 4'b1000;
        exp_q.push_back(model(4'hC, 4'b1000));
        cc_m = 4'b1000;
        tick();
        bus.flags_we = 1'b0; bus.flags_pending = 1'b0;
        chk("ge_valid_next", 4'(bus.br_valid), 4'd1);
        chk("ge_ready", 4'(bus.cond_ready), 4'd0);
        take_resp("ge");

        // WAIT released by flags_pending dropping, evaluated on the CC register
        bus.flags_pending = 1'b1;
        bus.cond_valid = 1'b1; bus.cond = 4'hB;
        tick();
        bus.cond_valid = 1'b0;
        chk("drop_wait", 4'(bus.br_valid), 4'd0);
        bus.flags_pending = 1'b0;
        exp_q.push_back(model(4'hB, cc_m));
        tick();
        take_resp("drop");

        // Hold in RESP for 4 cycles while flags change and a stray request is offered
        bus.cond_valid = 1'b1; bus.cond = 4'h6;
        exp_q.push_back(model(4'h6, cc_m));
        tick();
        bus.cond = 4'h1;
        for (int i = 0; i < 4; i++) begin
            bus.flags_we = 1'b1;
            bus.flags_in = 4'((i * 5 + 4) & 15);
            cc_m = bus.flags_in;
            chk("hold_valid", 4'(bus.br_valid), 4'd1);
            chk("hold_taken", 4'(bus.br_taken), 4'(exp_q[0]));
            tick();
        end
        bus.flags_we = 1'b0; bus.cond_valid = 1'b0;
        chk("hold_cc", bus.cc_out, cc_m);
        take_resp("hold");
        chk("hold_noqueue", 4'(bus.br_valid), 4'd0);
        chk("hold_ready", 4'(bus.cond_ready), 4'd1);

        // Full sweep: flags written first, then each condition from the CC register
        for (int f = 0; f < 16; f++) begin
            bus.flags_we = 1'b1; bus.flags_in = 4'(f);
            cc_m = 4'(f);
            tick();
            bus.flags_we = 1'b0;
            for (int c = 0; c < 16; c++) begin
                bus.cond_valid = 1'b1; bus.cond = 4'(c);
                exp_q.push_back(model(4'(c), cc_m));
                tick();
                bus.cond_valid = 1'b0;
                take_resp("sweep");
            end
        end

        // Reset while in WAIT, with a flag write in the reset cycle
        bus.flags_pending = 1'b1;
        bus.cond_valid = 1'b1; bus.cond = 4'h0;
        tick();
        bus.cond_valid = 1'b0;
        chk("rw_inwait", 4'(bus.cond_ready), 4'd0);
        rst_n = 1'b0;
        bus.flags_we = 1'b1; bus.flags_in = 4'b1111;
        tick();
        rst_n = 1'b1;
        bus.flags_we = 1'b0; bus.flags_pending = 1'b0;
        chk("rw_cc", bus.cc_out, CC_RESET);
        chk("rw_ready", 4'(bus.cond_ready), 4'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rw_nopulse", 4'(bus.br_valid), 4'd0);
            tick();
        end
        chk("sb_empty", 4'(exp_q.size()), 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
